// File: rtl/sram_master_if.sv
// ---------------------------------------------------------------------------
// sram_master_if
//
// FPGA-side initiator for an external asynchronous 1M x 16 SRAM. Accepts one
// request at a time on a valid/ready command port and turns it into a fully
// registered SRAM pin sequence:
//
//   write : WR_SETUP (1) -> WR_PULSE (WR_PULSE cycles, WE_B low) -> WR_HOLD (1)
//   read  : RD_WAIT (RD_WAIT cycles, OE_B low) -> RD_TURN (1, bus turnaround)
//
// Ports
//   BUS_CLK, BUS_RST        clock, synchronous active-high reset
//   REQ_VALID/REQ_READY     request handshake, accepted when both are high
//   REQ_WRITE               1 = write, 0 = read
//   REQ_ADDR[19:0]          word address, passed through unmodified
//   REQ_WDATA[15:0]         write data
//   REQ_BE[1:0]             byte enables (bit1 upper, bit0 lower), writes only
//   RD_VALID                one-cycle pulse when RD_DATA carries new data
//   RD_DATA[15:0]           last read word, held until the next read
//   SRAM_A, SRAM_IO         SRAM address / bidirectional data
//   SRAM_CE1_B, SRAM_OE_B, SRAM_WE_B, SRAM_BHE_B, SRAM_BLE_B
//                           active-low SRAM strobes
//
// Every SRAM-facing output comes from a flop. The next-cycle pin values are
// decoded from the next state, so the pins change exactly when the state does
// and no REQ_* input reaches a pin combinationally.
// ---------------------------------------------------------------------------
module sram_master_if #(
    parameter int WR_PULSE = 1,   // cycles WE_B is low per write (1..15)
    parameter int RD_WAIT  = 1    // cycles OE_B is low before sampling (1..15)
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,

    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [19:0] REQ_ADDR,
    input  logic [15:0] REQ_WDATA,
    input  logic [1:0]  REQ_BE,

    output logic        RD_VALID,
    output logic [15:0] RD_DATA,

    output logic [19:0] SRAM_A,
    inout  wire  [15:0] SRAM_IO,
    output logic        SRAM_BHE_B,
    output logic        SRAM_BLE_B,
    output logic        SRAM_CE1_B,
    output logic        SRAM_OE_B,
    output logic        SRAM_WE_B
);

    // Terminal counts for the two programmable-length states.
    localparam logic [3:0] WR_LAST = 4'(WR_PULSE - 1);
    localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RD_WAIT,
        S_RD_TURN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;

    // Request captured at accept; data-only, so no reset needed.
    logic [19:0] addr_q;
    logic [15:0] wdata_q;
    logic [1:0]  be_q;

    // Registered drive value and drive enable for SRAM_IO.
    logic [15:0] io_out;
    logic        io_drive;

    logic        accept;
    logic [19:0] sel_addr;
    logic [15:0] sel_wdata;
    logic [1:0]  sel_be;

    logic [19:0] a_nxt;
    logic [15:0] io_out_nxt;
    logic        io_drive_nxt;
    logic        ce_b_nxt;
    logic        oe_b_nxt;
    logic        we_b_nxt;
    logic        bhe_b_nxt;
    logic        ble_b_nxt;
    logic        ready_nxt;
    logic        rd_capture;

    // REQ_READY is only high in IDLE, so it doubles as the accept qualifier.
    assign accept = REQ_VALID && REQ_READY;

    assign SRAM_IO = io_drive ? io_out : 16'hzzzz;

    // -----------------------------------------------------------------------
    // Next-state and next-pin decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rd_capture   = 1'b0;

        // On the accept cycle the latched copy is not loaded yet, so the pin
        // values for the first operating cycle come straight from the request.
        sel_addr     = addr_q;
        sel_wdata    = wdata_q;
        sel_be       = be_q;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    sel_addr  = REQ_ADDR;
                    sel_wdata = REQ_WDATA;
                    sel_be    = REQ_BE;
                    cnt_nxt   = 4'd0;
                    state_nxt = REQ_WRITE ? S_WR_SETUP : S_RD_WAIT;
                end
            end
            S_WR_SETUP: begin
                state_nxt = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (cnt == WR_LAST) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = S_WR_HOLD;
                end else begin
                    cnt_nxt   = cnt + 4'd1;
                end
            end
            S_WR_HOLD: begin
                state_nxt = S_IDLE;
            end
            S_RD_WAIT: begin
                if (cnt == RD_LAST) begin
                    // Sample the bus on the edge that ends the last wait cycle.
                    rd_capture = 1'b1;
                    cnt_nxt    = 4'd0;
                    state_nxt  = S_RD_TURN;
                end else begin
                    cnt_nxt    = cnt + 4'd1;
                end
            end
            S_RD_TURN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Pin values for the cycle the FSM is about to enter.
        a_nxt        = SRAM_A;
        io_out_nxt   = io_out;
        io_drive_nxt = 1'b0;
        ce_b_nxt     = 1'b1;
        oe_b_nxt     = 1'b1;
        we_b_nxt     = 1'b1;
        bhe_b_nxt    = 1'b1;
        ble_b_nxt    = 1'b1;
        ready_nxt    = 1'b0;

        case (state_nxt)
            S_IDLE: begin
                ready_nxt = 1'b1;
            end
            S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: begin
                // Address, data and byte lanes stay constant across the whole
                // write so they bracket the WE_B low pulse on both sides.
                a_nxt        = sel_addr;
                io_out_nxt   = sel_wdata;
                io_drive_nxt = 1'b1;
                ce_b_nxt     = 1'b0;
                bhe_b_nxt    = ~sel_be[1];
                ble_b_nxt    = ~sel_be[0];
                we_b_nxt     = (state_nxt == S_WR_PULSE) ? 1'b0 : 1'b1;
            end
            S_RD_WAIT: begin
                // Reads always fetch the full word; the consumer picks bytes.
                a_nxt     = sel_addr;
                ce_b_nxt  = 1'b0;
                oe_b_nxt  = 1'b0;
                bhe_b_nxt = 1'b0;
                ble_b_nxt = 1'b0;
            end
            S_RD_TURN: begin
                // Everything deasserted: the SRAM releases IO before any
                // following write can start driving it.
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control and pin registers
    // -----------------------------------------------------------------------
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            REQ_READY  <= 1'b0;
            SRAM_A     <= 20'd0;
            io_drive   <= 1'b0;
            SRAM_CE1_B <= 1'b1;
            SRAM_OE_B  <= 1'b1;
            SRAM_WE_B  <= 1'b1;
            SRAM_BHE_B <= 1'b1;
            SRAM_BLE_B <= 1'b1;
            RD_VALID   <= 1'b0;
            RD_DATA    <= 16'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            REQ_READY  <= ready_nxt;
            SRAM_A     <= a_nxt;
            io_drive   <= io_drive_nxt;
            SRAM_CE1_B <= ce_b_nxt;
            SRAM_OE_B  <= oe_b_nxt;
            SRAM_WE_B  <= we_b_nxt;
            SRAM_BHE_B <= bhe_b_nxt;
            SRAM_BLE_B <= ble_b_nxt;
            RD_VALID   <= rd_capture;
            if (rd_capture) begin
                RD_DATA <= SRAM_IO;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Request capture and write-data register
    // -----------------------------------------------------------------------
    always_ff @(posedge BUS_CLK) begin
        io_out <= io_out_nxt;
        if (accept) begin
            addr_q  <= REQ_ADDR;
            wdata_q <= REQ_WDATA;
            be_q    <= REQ_BE;
        end
    end

endmodule
